// File: rtl/alsu_verificador.sv
// rtl/alsu_verificador.sv - golden-model checker aligned to a pipelined 16-bit ALSU
module alsu_verificador #(
  parameter int LATENCIA       = 1,
  parameter int CONT_ANCHO     = 16,
  parameter bit PARAR_EN_FALLO = 1'b0
) (
  input  logic                  Reloj,
  input  logic                  Reset,
  input  logic                  Valido,
  input  logic [15:0]           TuplaA,
  input  logic [15:0]           TuplaB,
  input  logic [3:0]            Funcion,
  input  logic [15:0]           Respuesta,
  input  logic                  Cy,
  input  logic                  Ov,
  output logic                  Comparado,
  output logic [CONT_ANCHO-1:0] Correctos,
  output logic [CONT_ANCHO-1:0] Errores,
  output logic                  Fallo,
  output logic                  Detenido,
  output logic [3:0]            PrimerFuncion,
  output logic [17:0]           PrimerEsperado,
  output logic [17:0]           PrimerObtenido
);

  typedef enum logic {ACTIVO = 1'b0, DETENIDO = 1'b1} estado_t;

  localparam logic [CONT_ANCHO-1:0] CONT_MAX = {CONT_ANCHO{1'b1}};

  logic [16:0] suma;
  logic [15:0] res;
  logic        cy_e;
  logic        ov_e;
  logic [17:0] esperado;

  // Subtractions use A + ~B + 1, so bit 16 is the NOT-borrow carry.
  always_comb begin
    suma = 17'd0;
    res  = 16'd0;
    cy_e = 1'b0;
    ov_e = 1'b0;
    case (Funcion)
      4'h0: begin
        suma = {1'b0, TuplaA} + {1'b0, TuplaB};
        res  = suma[15:0];
        cy_e = suma[16];
        ov_e = (TuplaA[15] == TuplaB[15]) && (suma[15] != TuplaA[15]);
      end
      4'h1: begin
        suma = {1'b0, TuplaA} + {1'b0, ~TuplaB} + 17'd1;
        res  = suma[15:0];
        cy_e = suma[16];
        ov_e = (TuplaA[15] != TuplaB[15]) && (suma[15] != TuplaA[15]);
      end
      4'h2: begin
        suma = {1'b0, TuplaA} + 17'd1;
        res  = suma[15:0];
        cy_e = suma[16];
        ov_e = ~TuplaA[15] & suma[15];
      end
      4'h3: begin
        suma = {1'b0, TuplaA} + 17'h0_FFFF;
        res  = suma[15:0];
        cy_e = suma[16];
        ov_e = TuplaA[15] & ~suma[15];
      end
      4'h4: res = TuplaA & TuplaB;
      4'h5: res = TuplaA | TuplaB;
      4'h6: res = TuplaA ^ TuplaB;
      4'h7: res = ~TuplaA;
      4'h8: begin
        res  = {TuplaA[14:0], 1'b0};
        cy_e = TuplaA[15];
      end
      4'h9: begin
        res  = {1'b0, TuplaA[15:1]};
        cy_e = TuplaA[0];
      end
      4'hA: begin
        res  = {TuplaA[15], TuplaA[15:1]};
        cy_e = TuplaA[0];
      end
      4'hB: begin
        res  = {TuplaA[14:0], TuplaA[15]};
        cy_e = TuplaA[15];
      end
      4'hC: begin
        res  = {TuplaA[0], TuplaA[15:1]};
        cy_e = TuplaA[0];
      end
      4'hD: res = TuplaB;
      4'hE: begin
        suma = {1'b0, ~TuplaA} + 17'd1;
        res  = suma[15:0];
        cy_e = suma[16];
        ov_e = (TuplaA == 16'h8000);
      end
      default: res = 16'd0;
    endcase
  end

  assign esperado = {cy_e, ov_e, res};

  logic        cola_valido;
  logic [3:0]  cola_funcion;
  logic [17:0] cola_esperado;

  generate
    if (LATENCIA == 0) begin : g_directo
      assign cola_valido   = Valido;
      assign cola_funcion  = Funcion;
      assign cola_esperado = esperado;
    end else begin : g_linea
      logic [22:0] linea_q [LATENCIA];
      logic [22:0] linea_d [LATENCIA];

      always_comb begin
        linea_d[0] = {Valido, Funcion, esperado};
        for (int i = 1; i < LATENCIA; i++) begin
          linea_d[i] = linea_q[i-1];
        end
      end

      always_ff @(posedge Reloj) begin
        for (int i = 0; i < LATENCIA; i++) begin
          if (Reset) begin
            linea_q[i] <= 23'd0;
          end else begin
            linea_q[i] <= linea_d[i];
          end
        end
      end

      assign {cola_valido, cola_funcion, cola_esperado} = linea_q[LATENCIA-1];
    end
  endgenerate

  estado_t               estado_q, estado_d;
  logic                  comparado_q, comparado_d;
  logic [CONT_ANCHO-1:0] correctos_q, correctos_d;
  logic [CONT_ANCHO-1:0] errores_q, errores_d;
  logic                  fallo_q, fallo_d;
  logic [3:0]            primer_funcion_q, primer_funcion_d;
  logic [17:0]           primer_esperado_q, primer_esperado_d;
  logic [17:0]           primer_obtenido_q, primer_obtenido_d;

  logic [17:0] obtenido;
  logic        comparar;
  logic        discrepa;

  assign obtenido = {Cy, Ov, Respuesta};
  assign comparar = (estado_q == ACTIVO) && cola_valido;
  assign discrepa = (obtenido != cola_esperado);

  always_comb begin
    estado_d          = estado_q;
    comparado_d       = comparar;
    correctos_d       = correctos_q;
    errores_d         = errores_q;
    fallo_d           = fallo_q;
    primer_funcion_d  = primer_funcion_q;
    primer_esperado_d = primer_esperado_q;
    primer_obtenido_d = primer_obtenido_q;
    if (comparar) begin
      if (discrepa) begin
        if (errores_q != CONT_MAX) begin
          errores_d = errores_q + 1'b1;
        end
        fallo_d = 1'b1;
        if (!fallo_q) begin
          primer_funcion_d  = cola_funcion;
          primer_esperado_d = cola_esperado;
          primer_obtenido_d = obtenido;
        end
        if (PARAR_EN_FALLO) begin
          estado_d = DETENIDO;
        end
      end else if (correctos_q != CONT_MAX) begin
        correctos_d = correctos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Reloj) begin
    if (Reset) begin
      estado_q          <= ACTIVO;
      comparado_q       <= 1'b0;
      correctos_q       <= '0;
      errores_q         <= '0;
      fallo_q           <= 1'b0;
      primer_funcion_q  <= 4'd0;
      primer_esperado_q <= 18'd0;
      primer_obtenido_q <= 18'd0;
    end else begin
      estado_q          <= estado_d;
      comparado_q       <= comparado_d;
      correctos_q       <= correctos_d;
      errores_q         <= errores_d;
      fallo_q           <= fallo_d;
      primer_funcion_q  <= primer_funcion_d;
      primer_esperado_q <= primer_esperado_d;
      primer_obtenido_q <= primer_obtenido_d;
    end
  end

  assign Comparado      = comparado_q;
  assign Correctos      = correctos_q;
  assign Errores        = errores_q;
  assign Fallo          = fallo_q;
  assign Detenido       = (estado_q == DETENIDO);
  assign PrimerFuncion  = primer_funcion_q;
  assign PrimerEsperado = primer_esperado_q;
  assign PrimerObtenido = primer_obtenido_q;

endmodule

// File: tb/tb_alsu_verificador.sv
// tb/tb_alsu_verificador.sv - scoreboard bench for alsu_verificador
module tb_alsu_verificador;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        valido = 1'b0;
  logic        inj = 1'b0;
  logic [15:0] ta = 16'd0;
  logic [15:0] tb_b = 16'd0;
  logic [3:0]  fn = 4'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] ref_alsu(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, full, sv;
    logic c, o, arit;
    logic [15:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    full = 0; sv = 0; c = 1'b0; o = 1'b0; r = 16'd0; arit = 1'b0;
    case (f)
      4'h0: begin full = ua + ub; sv = sa + sb; arit = 1'b1; end
      4'h1: begin full = ua + (ub ^ 32'hFFFF) + 1; sv = sa - sb; arit = 1'b1; end
      4'h2: begin full = ua + 1; sv = sa + 1; arit = 1'b1; end
      4'h3: begin full = ua + 32'hFFFF; sv = sa - 1; arit = 1'b1; end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: begin r = a << 1; c = a[15]; end
      4'h9: begin r = a >> 1; c = a[0]; end
      4'hA: begin r = $signed(a) >>> 1; c = a[0]; end
      4'hB: begin r = (a << 1) | (a >> 15); c = a[15]; end
      4'hC: begin r = (a >> 1) | (a << 15); c = a[0]; end
      4'hD: r = b;
      4'hE: begin full = (ua ^ 32'hFFFF) + 1; sv = -sa; arit = 1'b1; end
      default: r = 16'd0;
    endcase
    if (arit) begin
      r = full[15:0];
      c = (full > 65535);
      o = (sv > 32767) || (sv < -32768);
    end
    return {c, o, r};
  endfunction

  logic [17:0] golden_now;
  logic [17:0] d1 = 18'd0;
  logic [17:0] d2 = 18'd0;
  always_comb golden_now = ref_alsu(fn, ta, tb_b);
  always @(posedge clk) begin
    d1 <= {golden_now[17:16], golden_now[15:0] ^ {15'd0, inj}};
    d2 <= d1;
  end

  logic        comp_w [4];
  logic        fallo_w [4];
  logic        det_w [4];
  logic [3:0]  pf_w [4];
  logic [17:0] pe_w [4];
  logic [17:0] po_w [4];
  logic [15:0] ok0, ok1, ok2, err0, err1, err2;
  logic [3:0]  ok_s, err_s;

  alsu_verificador #(.LATENCIA(0), .CONT_ANCHO(16), .PARAR_EN_FALLO(1'b0)) u_l0 (
    .Reloj(clk), .Reset(rst), .Valido(valido), .TuplaA(ta), .TuplaB(tb_b), .Funcion(fn),
    .Respuesta(golden_now[15:0] ^ {15'd0, inj}), .Cy(golden_now[17]), .Ov(golden_now[16]),
    .Comparado(comp_w[0]), .Correctos(ok0), .Errores(err0), .Fallo(fallo_w[0]), .Detenido(det_w[0]),
    .PrimerFuncion(pf_w[0]), .PrimerEsperado(pe_w[0]), .PrimerObtenido(po_w[0]));

  alsu_verificador #(.LATENCIA(2), .CONT_ANCHO(16), .PARAR_EN_FALLO(1'b0)) u_l2 (
    .Reloj(clk), .Reset(rst), .Valido(valido), .TuplaA(ta), .TuplaB(tb_b), .Funcion(fn),
    .Respuesta(d2[15:0]), .Cy(d2[17]), .Ov(d2[16]),
    .Comparado(comp_w[1]), .Correctos(ok1), .Errores(err1), .Fallo(fallo_w[1]), .Detenido(det_w[1]),
    .PrimerFuncion(pf_w[1]), .PrimerEsperado(pe_w[1]), .PrimerObtenido(po_w[1]));

  alsu_verificador #(.LATENCIA(2), .CONT_ANCHO(16), .PARAR_EN_FALLO(1'b1)) u_st (
    .Reloj(clk), .Reset(rst), .Valido(valido), .TuplaA(ta), .TuplaB(tb_b), .Funcion(fn),
    .Respuesta(d2[15:0]), .Cy(d2[17]), .Ov(d2[16]),
    .Comparado(comp_w[2]), .Correctos(ok2), .Errores(err2), .Fallo(fallo_w[2]), .Detenido(det_w[2]),
    .PrimerFuncion(pf_w[2]), .PrimerEsperado(pe_w[2]), .PrimerObtenido(po_w[2]));

  alsu_verificador #(.LATENCIA(0), .CONT_ANCHO(4), .PARAR_EN_FALLO(1'b0)) u_sat (
    .Reloj(clk), .Reset(rst), .Valido(valido), .TuplaA(ta), .TuplaB(tb_b), .Funcion(fn),
    .Respuesta(golden_now[15:0] ^ {15'd0, inj}), .Cy(golden_now[17]), .Ov(golden_now[16]),
    .Comparado(comp_w[3]), .Correctos(ok_s), .Errores(err_s), .Fallo(fallo_w[3]), .Detenido(det_w[3]),
    .PrimerFuncion(pf_w[3]), .PrimerEsperado(pe_w[3]), .PrimerObtenido(po_w[3]));

  logic [1:0]  sel = 2'd0;
  logic        m_comp, m_fallo, m_det;
  logic [15:0] m_ok, m_err;
  logic [3:0]  m_pf;
  logic [17:0] m_pe, m_po;

  always_comb begin
    m_comp  = comp_w[sel];
    m_fallo = fallo_w[sel];
    m_det   = det_w[sel];
    m_pf    = pf_w[sel];
    m_pe    = pe_w[sel];
    m_po    = po_w[sel];
    case (sel)
      2'd0:    begin m_ok = ok0; m_err = err0; end
      2'd1:    begin m_ok = ok1; m_err = err1; end
      2'd2:    begin m_ok = ok2; m_err = err2; end
      default: begin m_ok = {12'd0, ok_s}; m_err = {12'd0, err_s}; end
    endcase
  end

  typedef struct {
    logic [3:0]  f;
    logic [17:0] e;
    logic [17:0] o;
  } sb_t;

  sb_t  sb[$];
  sb_t  cur;
  logic mon_en = 1'b0;
  int   exp_ok = 0, exp_err = 0, sat_max = 65535;
  int   pulses = 0, first_pulse = 0, last_pulse = 0;
  logic exp_fallo = 1'b0;

  // Each Comparado pulse retires the oldest outstanding vector.
  always @(negedge clk) begin
    if (mon_en && m_comp === 1'b1) begin
      if (pulses == 0) first_pulse = cyc;
      last_pulse = cyc;
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_comparado got 1 want 0 at cycle %0d", cyc);
      end else begin
        cur = sb.pop_front();
        if (cur.e == cur.o) begin
          if (exp_ok < sat_max) exp_ok++;
        end else begin
          if (exp_err < sat_max) exp_err++;
          exp_fallo = 1'b1;
        end
        checks++;
        if (m_ok !== 16'(exp_ok)) begin
          errors++;
          $display("FAIL sb_correctos got %0d want %0d", m_ok, exp_ok);
        end
        checks++;
        if (m_err !== 16'(exp_err)) begin
          errors++;
          $display("FAIL sb_errores got %0d want %0d", m_err, exp_err);
        end
        if (m_fallo !== exp_fallo) begin
          errors++;
          $display("FAIL sb_fallo got %0b want %0b", m_fallo, exp_fallo);
        end
      end
    end
  end

  task automatic do_reset(input logic [1:0] s, input int smax);
    mon_en = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; valido = 1'b0; inj = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    sb.delete();
    exp_ok = 0; exp_err = 0; exp_fallo = 1'b0; pulses = 0;
    sel = s; sat_max = smax; mon_en = 1'b1;
  endtask

  task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic err, input bit push);
    sb_t e;
    logic [17:0] g;
    @(posedge clk); #2;
    valido = 1'b1; fn = f; ta = a; tb_b = b; inj = err;
    g = ref_alsu(f, a, b);
    e.f = f; e.e = g; e.o = {g[17:16], g[15:0] ^ {15'd0, err}};
    if (push) sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      valido = 1'b0; inj = 1'b0;
    end
  endtask

  task automatic test_reset;
    do_reset(2'd0, 65535);
    checks++; if (m_comp !== 1'b0) begin errors++; $display("FAIL reset_comparado got %0b want 0", m_comp); end
    checks++; if (m_ok !== 16'd0) begin errors++; $display("FAIL reset_correctos got %0d want 0", m_ok); end
    checks++; if (m_err !== 16'd0) begin errors++; $display("FAIL reset_errores got %0d want 0", m_err); end
    checks++; if (m_fallo !== 1'b0) begin errors++; $display("FAIL reset_fallo got %0b want 0", m_fallo); end
    checks++; if (det_w[2] !== 1'b0) begin errors++; $display("FAIL reset_detenido got %0b want 0", det_w[2]); end
    checks++; if (m_pf !== 4'd0) begin errors++; $display("FAIL reset_pfuncion got %0h want 0", m_pf); end
    checks++; if (m_pe !== 18'd0) begin errors++; $display("FAIL reset_pesperado got %0h want 0", m_pe); end
    checks++; if (m_po !== 18'd0) begin errors++; $display("FAIL reset_pobtenido got %0h want 0", m_po); end
  endtask

  task automatic test_sweep(input logic [15:0] a, input logic [15:0] b);
    do_reset(2'd0, 65535);
    for (int f = 0; f < 16; f++) drive(4'(f), a, b, 1'b0, 1'b1);
    idle(4);
    checks++; if (m_ok !== 16'd16) begin errors++; $display("FAIL sweep_%0h_correctos got %0d want 16", a, m_ok); end
    checks++; if (m_err !== 16'd0) begin errors++; $display("FAIL sweep_%0h_errores got %0d want 0", a, m_err); end
    checks++; if (m_fallo !== 1'b0) begin errors++; $display("FAIL sweep_%0h_fallo got %0b want 0", a, m_fallo); end
    checks++; if (pulses != 16) begin errors++; $display("FAIL sweep_%0h_pulses got %0d want 16", a, pulses); end
  endtask

  task automatic test_no_valid;
    do_reset(2'd0, 65535);
    repeat (6) begin
      @(posedge clk); #2;
      valido = 1'b0; inj = 1'b1;
      fn = 4'($urandom_range(0, 15)); ta = 16'($urandom()); tb_b = 16'($urandom());
    end
    idle(3);
    checks++; if (pulses != 0) begin errors++; $display("FAIL novalid_pulses got %0d want 0", pulses); end
    checks++; if (m_err !== 16'd0) begin errors++; $display("FAIL novalid_errores got %0d want 0", m_err); end
  endtask

  task automatic test_back_to_back;
    int first_valid;
    do_reset(2'd1, 65535);
    for (int i = 0; i < 10; i++) begin
      drive(4'($urandom_range(0, 15)), 16'($urandom()), 16'($urandom()), 1'b0, 1'b1);
      if (i == 0) first_valid = cyc;
    end
    idle(6);
    checks++; if (pulses != 10) begin errors++; $display("FAIL b2b_pulses got %0d want 10", pulses); end
    checks++; if (first_pulse - first_valid != 3) begin errors++; $display("FAIL b2b_first_latency got %0d want 3", first_pulse - first_valid); end
    checks++; if (last_pulse - first_pulse != 9) begin errors++; $display("FAIL b2b_span got %0d want 9", last_pulse - first_pulse); end
    checks++; if (m_ok !== 16'd10) begin errors++; $display("FAIL b2b_correctos got %0d want 10", m_ok); end
  endtask

  task automatic test_error_inject;
    do_reset(2'd1, 65535);
    drive(4'h0, 16'h1234, 16'h1111, 1'b0, 1'b1);
    drive(4'h6, 16'hA5A5, 16'h0FF0, 1'b0, 1'b1);
    drive(4'h1, 16'h0007, 16'h0001, 1'b1, 1'b1);
    drive(4'h5, 16'h8000, 16'h0003, 1'b0, 1'b1);
    drive(4'h2, 16'h0005, 16'h0000, 1'b1, 1'b1);
    drive(4'hD, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    idle(6);
    checks++; if (m_err !== 16'd2) begin errors++; $display("FAIL inj_errores got %0d want 2", m_err); end
    checks++; if (m_ok !== 16'd4) begin errors++; $display("FAIL inj_correctos got %0d want 4", m_ok); end
    checks++; if (m_fallo !== 1'b1) begin errors++; $display("FAIL inj_fallo got %0b want 1", m_fallo); end
    checks++; if (m_pf !== 4'h1) begin errors++; $display("FAIL inj_pfuncion got %0h want 1", m_pf); end
    checks++; if (m_pe !== 18'h2_0006) begin errors++; $display("FAIL inj_pesperado got %0h want 20006", m_pe); end
    checks++; if (m_po !== 18'h2_0007) begin errors++; $display("FAIL inj_pobtenido got %0h want 20007", m_po); end
  endtask

  task automatic test_stop;
    do_reset(2'd2, 65535);
    for (int i = 0; i < 8; i++) begin
      drive(4'($urandom_range(0, 15)), 16'($urandom()), 16'($urandom()), (i == 3), 1'b1);
      if (i == 5) begin
        checks++; if (m_det !== 1'b0) begin errors++; $display("FAIL stop_detenido_early got %0b want 0", m_det); end
      end
      if (i == 6) begin
        checks++; if (m_det !== 1'b1) begin errors++; $display("FAIL stop_detenido_edge got %0b want 1", m_det); end
      end
    end
    idle(8);
    checks++; if (m_det !== 1'b1) begin errors++; $display("FAIL stop_detenido got %0b want 1", m_det); end
    checks++; if (m_ok !== 16'd3) begin errors++; $display("FAIL stop_correctos got %0d want 3", m_ok); end
    checks++; if (m_err !== 16'd1) begin errors++; $display("FAIL stop_errores got %0d want 1", m_err); end
    checks++; if (pulses != 4) begin errors++; $display("FAIL stop_pulses got %0d want 4", pulses); end
    do_reset(2'd2, 65535);
    checks++; if (m_det !== 1'b0) begin errors++; $display("FAIL stop_reset_detenido got %0b want 0", m_det); end
    checks++; if (m_ok !== 16'd0 || m_err !== 16'd0) begin errors++; $display("FAIL stop_reset_counts got %0d/%0d want 0/0", m_ok, m_err); end
    checks++; if (m_fallo !== 1'b0 || m_pe !== 18'd0) begin errors++; $display("FAIL stop_reset_fallo got %0b/%0h want 0/0", m_fallo, m_pe); end
  endtask

  task automatic test_reset_in_flight;
    do_reset(2'd1, 65535);
    drive(4'h0, 16'h0001, 16'h0002, 1'b0, 1'b0);
    drive(4'h4, 16'h00FF, 16'h0F0F, 1'b1, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1; valido = 1'b0; inj = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    idle(6);
    checks++; if (pulses != 0) begin errors++; $display("FAIL flight_pulses got %0d want 0", pulses); end
    checks++; if (m_ok !== 16'd0 || m_err !== 16'd0) begin errors++; $display("FAIL flight_counts got %0d/%0d want 0/0", m_ok, m_err); end
  endtask

  task automatic test_saturation;
    do_reset(2'd3, 15);
    for (int i = 0; i < 20; i++) drive(4'($urandom_range(0, 15)), 16'($urandom()), 16'($urandom()), 1'b0, 1'b1);
    idle(4);
    checks++; if (m_ok !== 16'h000F) begin errors++; $display("FAIL sat_correctos got %0h want f", m_ok); end
    checks++; if (m_err !== 16'd0) begin errors++; $display("FAIL sat_errores got %0d want 0", m_err); end
    checks++; if (pulses != 20) begin errors++; $display("FAIL sat_pulses got %0d want 20", pulses); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sweep(16'hFFFF, 16'h0001);
    test_sweep(16'h7FFF, 16'h0001);
    test_no_valid();
    test_back_to_back();
    test_error_inject();
    test_stop();
    test_reset_in_flight();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
